// File: rtl/multicycle_ctrl.sv
// Main sequencer of the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB with memory timeout.
// Latency: every output is registered; pulses appear the cycle after the deciding state (ALU 4, branch 3, load 5, store 4 + waits).
// Backpressure: imem_req/dmem_req held until ack (acks ignored while no request); TIMEOUT waits -> sticky bus_err + HALT.
// Optional: define TRAP_ILLEGAL_EN to trap unknown opcodes (adds sticky 'illegal' output); otherwise they act as NOPs.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       halted,
`ifdef TRAP_ILLEGAL_EN
    output logic       illegal,
`endif
    output logic       bus_err
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    logic       imem_req_q, imem_req_d;
    logic       dmem_req_q, dmem_req_d;
    logic       dmem_we_q, dmem_we_d;
    logic       ir_we_q, ir_we_d;
    logic       pc_we_q, pc_we_d;
    logic [1:0] pc_sel_q, pc_sel_d;
    logic       alu_a_sel_q, alu_a_sel_d;
    logic       alu_b_sel_q, alu_b_sel_d;
    logic       rf_we_q, rf_we_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic       halted_q, halted_d;
    logic       bus_err_q, bus_err_d;
    logic       illegal_q, illegal_d;

    // funct3 only matters to the memory/ALU datapath; sequencing ignores it.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    // State, wait counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            cnt_q       <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            ir_we_q     <= 1'b0;
            pc_we_q     <= 1'b0;
            pc_sel_q    <= 2'd0;
            alu_a_sel_q <= 1'b0;
            alu_b_sel_q <= 1'b0;
            rf_we_q     <= 1'b0;
            wb_sel_q    <= 2'd0;
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            ir_we_q     <= ir_we_d;
            pc_we_q     <= pc_we_d;
            pc_sel_q    <= pc_sel_d;
            alu_a_sel_q <= alu_a_sel_d;
            alu_b_sel_q <= alu_b_sel_d;
            rf_we_q     <= rf_we_d;
            wb_sel_q    <= wb_sel_d;
            halted_q    <= halted_d;
            bus_err_q   <= bus_err_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next state and wait counter; an ack only counts while our request is actually on the bus.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ack)               state_d = ST_DECODE;
                    else if (cnt_q == CNT_LAST) begin
                        state_d     = ST_HALT;
                        timeout_hit = 1'b1;
                    end else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_SYSTEM:   state_d = ST_HALT;
                    OPC_MISC_MEM: state_d = ST_FETCH;
                    OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                    OPC_BRANCH, OPC_JAL, OPC_JALR:
                                  state_d = ST_EXEC;
`ifdef TRAP_ILLEGAL_EN
                    default:      state_d = ST_TRAP;
`else
                    default:      state_d = ST_FETCH;
`endif
                endcase
            end
            ST_EXEC: begin
                if (opcode == OPC_LOAD || opcode == OPC_STORE) state_d = ST_MEM;
                else if (opcode == OPC_BRANCH)                 state_d = ST_FETCH;
                else                                           state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_req_q) begin
                    if (dmem_ack)               state_d = (opcode == OPC_STORE) ? ST_FETCH : ST_WB;
                    else if (cnt_q == CNT_LAST) begin
                        state_d     = ST_HALT;
                        timeout_hit = 1'b1;
                    end else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = state_q;
        endcase
        // Each new bus access gets a fresh timeout budget.
        if (state_d != state_q && (state_d == ST_FETCH || state_d == ST_MEM)) cnt_d = '0;
    end

    // Output decode: requests follow the next state, enable pulses follow the transition taken.
    always_comb begin
        imem_req_d  = (state_d == ST_FETCH);
        dmem_req_d  = (state_d == ST_MEM);
        dmem_we_d   = (state_d == ST_MEM) && (opcode == OPC_STORE);
        ir_we_d     = (state_q == ST_FETCH) && (state_d == ST_DECODE);
        pc_we_d     = 1'b0;
        pc_sel_d    = 2'd0;
        rf_we_d     = 1'b0;
        wb_sel_d    = 2'd0;
        alu_a_sel_d = 1'b0;
        alu_b_sel_d = 1'b0;
        case (state_q)
            ST_DECODE: pc_we_d = (state_d == ST_FETCH);
            ST_EXEC: begin
                if (opcode == OPC_BRANCH) begin
                    pc_we_d  = 1'b1;
                    pc_sel_d = br_taken ? 2'd1 : 2'd0;
                end
            end
            ST_MEM:    pc_we_d = (state_d == ST_FETCH);
            ST_WB: begin
                rf_we_d = 1'b1;
                pc_we_d = 1'b1;
                if (opcode == OPC_LOAD)                           wb_sel_d = 2'd1;
                else if (opcode == OPC_JAL || opcode == OPC_JALR) wb_sel_d = 2'd2;
                if (opcode == OPC_JAL)       pc_sel_d = 2'd1;
                else if (opcode == OPC_JALR) pc_sel_d = 2'd2;
            end
            default: ;
        endcase
        // ALU operand selects stay valid for the whole execute/memory/write-back span.
        if (state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) begin
            case (opcode)
                OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: alu_b_sel_d = 1'b1;
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                    alu_a_sel_d = 1'b1;
                    alu_b_sel_d = 1'b1;
                end
                default: ;
            endcase
        end
        halted_d  = halted_q || (state_d == ST_HALT) || (state_d == ST_TRAP);
        bus_err_d = bus_err_q || timeout_hit;
        illegal_d = illegal_q || (state_d == ST_TRAP);
    end

    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign ir_we     = ir_we_q;
    assign pc_we     = pc_we_q;
    assign pc_sel    = pc_sel_q;
    assign alu_a_sel = alu_a_sel_q;
    assign alu_b_sel = alu_b_sel_q;
    assign rf_we     = rf_we_q;
    assign wb_sel    = wb_sel_q;
    assign halted    = halted_q;
    assign bus_err   = bus_err_q;
`ifdef TRAP_ILLEGAL_EN
    assign illegal   = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl with TIMEOUT=4.
// Expected enable pulses are queued per instruction, observed pulses captured per cycle, then popped and compared.
// Acks are driven by a small bus responder with configurable wait counts.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic       ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, halted, bus_err, illegal;
    logic [1:0] pc_sel, wb_sel;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted),
`ifdef TRAP_ILLEGAL_EN
        .illegal(illegal),
`endif
        .bus_err(bus_err)
    );
`ifndef TRAP_ILLEGAL_EN
    assign illegal = 1'b0;
`endif

    // {cycle, ir_we, pc_we, pc_sel, rf_we, wb_sel}
    typedef struct packed {
        logic [7:0] cyc;
        logic       ir;
        logic       pcw;
        logic [1:0] psel;
        logic       rfw;
        logic [1:0] wsel;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  e, o;
    int   total = 0;
    int   bad = 0;
    logic [1:0] obs_alu;
    logic       obs_dwe;
    int   obs_mreq;
    int   obs_halt_c;

    // Hold reset across two edges, release on a falling edge, then step to the first requesting cycle.
    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        opcode = 5'b01100; funct3 = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Run one instruction from a FETCH cycle with imem_req high; capture pulses until pc_we, halt or budget.
    task automatic run_instr(input logic [4:0] opc, input logic br, input int fwait, input int mwait);
        int c = 0;
        int fw = 0;
        int mw = 0;
        bit done = 1'b0;
        obs_q.delete();
        obs_alu = 2'bxx; obs_dwe = 1'bx; obs_mreq = 0; obs_halt_c = -1;
        opcode = opc; funct3 = 3'b010; br_taken = br;
        while (!done && c < 60) begin
            if (c != 0 && (ir_we || pc_we || rf_we))
                obs_q.push_back({8'(c), ir_we, pc_we, pc_sel, rf_we, wb_sel});
            if (c == 2) obs_alu = {alu_a_sel, alu_b_sel};
            if (dmem_req) begin obs_mreq++; obs_dwe = dmem_we; end
            imem_ack = 1'b0; dmem_ack = 1'b0;
            if (halted && obs_halt_c < 0) obs_halt_c = c;
            if (c != 0 && (pc_we || halted)) done = 1'b1;
            else begin
                if (imem_req) begin if (fw == fwait) imem_ack = 1'b1; fw++; end
                if (dmem_req) begin if (mw == mwait) dmem_ack = 1'b1; mw++; end
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        opcode = 5'b01100; funct3 = 3'b000;
        repeat (2) @(negedge clk);
        total++;
        if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
             rf_we, wb_sel, halted, bus_err, illegal} !== 15'd0) begin
            bad++; $display("FAIL reset_outputs got req=%b ir=%b pc=%b halt=%b err=%b want all 0",
                            imem_req, ir_we, pc_we, halted, bus_err);
        end
        // Ack during the first post-reset cycle arrives with no request outstanding and must be ignored.
        rst_n = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL reset_fetch_req got %b want 1", imem_req); end
        @(negedge clk);
        total++;
        if (ir_we !== 1'b0 || imem_req !== 1'b1) begin
            bad++; $display("FAIL stray_ack got ir_we=%b imem_req=%b want 0 1", ir_we, imem_req);
        end
    endtask

    task automatic test_alu_ops();
        logic [4:0] opc_t [6] = '{5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11011, 5'b11001};
        logic [1:0] alu_t [6] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01};
        logic [1:0] wb_t  [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
        logic [1:0] ps_t  [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
            exp_q.push_back({8'd4, 1'b0, 1'b1, ps_t[i], 1'b1, wb_t[i]});
            run_instr(opc_t[i], 1'b0, 0, 0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
                total++;
                if (o !== e) begin bad++; $display("FAIL alu_ev op=%b got=%h want=%h", opc_t[i], o, e); end
            end
            total++;
            if (obs_q.size() != 0 || obs_alu !== alu_t[i]) begin
                bad++; $display("FAIL alu_sel op=%b got=%b extra=%0d want=%b", opc_t[i], obs_alu, obs_q.size(), alu_t[i]);
            end
        end
    endtask

    task automatic test_load_store();
        // LW with three wait cycles; the ack lands on the last cycle before timeout.
        exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
        exp_q.push_back({8'd8, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1});
        run_instr(5'b00000, 1'b0, 0, 3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            total++;
            if (o !== e) begin bad++; $display("FAIL load_ev got=%h want=%h", o, e); end
        end
        total++;
        if (obs_dwe !== 1'b0 || obs_mreq != 4 || bus_err !== 1'b0) begin
            bad++; $display("FAIL load_mem got we=%b req_cycles=%0d err=%b want 0 4 0", obs_dwe, obs_mreq, bus_err);
        end
        // SW with immediate ack: PC update only.
        exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
        exp_q.push_back({8'd4, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0});
        run_instr(5'b01000, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            total++;
            if (o !== e) begin bad++; $display("FAIL store_ev got=%h want=%h", o, e); end
        end
        total++;
        if (obs_dwe !== 1'b1 || obs_mreq != 1 || obs_alu !== 2'b01) begin
            bad++; $display("FAIL store_mem got we=%b req_cycles=%0d alu=%b want 1 1 01", obs_dwe, obs_mreq, obs_alu);
        end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
            exp_q.push_back({8'd3, 1'b0, 1'b1, (t == 1) ? 2'd1 : 2'd0, 1'b0, 2'd0});
            run_instr(5'b11000, t[0], 0, 0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
                total++;
                if (o !== e) begin bad++; $display("FAIL branch_ev taken=%0d got=%h want=%h", t, o, e); end
            end
            total++;
            if (obs_alu !== 2'b11) begin bad++; $display("FAIL branch_alu got=%b want 11", obs_alu); end
        end
    endtask

    task automatic test_fence_nop();
        exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
        exp_q.push_back({8'd2, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0});
        run_instr(5'b00011, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            total++;
            if (o !== e) begin bad++; $display("FAIL fence_ev got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_ack_on_timeout_cycle();
        exp_q.push_back({8'd4, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
        exp_q.push_back({8'd7, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0});
        run_instr(5'b01100, 1'b0, 3, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            total++;
            if (o !== e) begin bad++; $display("FAIL ack_wins_ev got=%h want=%h", o, e); end
        end
        total++;
        if (bus_err !== 1'b0 || halted !== 1'b0) begin
            bad++; $display("FAIL ack_wins_err got err=%b halt=%b want 0 0", bus_err, halted);
        end
    endtask

    task automatic test_system_halt();
        exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
        run_instr(5'b11100, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            total++;
            if (o !== e) begin bad++; $display("FAIL ecall_ev got=%h want=%h", o, e); end
        end
        total++;
        if (obs_halt_c != 2 || obs_q.size() != 0) begin
            bad++; $display("FAIL ecall_halt got cycle=%0d extra=%0d want 2 0", obs_halt_c, obs_q.size());
        end
        imem_ack = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc_we !== 1'b0 || bus_err !== 1'b0) begin
            bad++; $display("FAIL ecall_sticky got halt=%b req=%b pc_we=%b err=%b want 1 0 0 0", halted, imem_req, pc_we, bus_err);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        exp_q.push_back({8'd1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0});
`ifndef TRAP_ILLEGAL_EN
        exp_q.push_back({8'd2, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0});
`endif
        run_instr(5'b11111, 1'b0, 0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            total++;
            if (o !== e) begin bad++; $display("FAIL illegal_ev got=%h want=%h", o, e); end
        end
`ifdef TRAP_ILLEGAL_EN
        total++;
        if (obs_halt_c != 2 || illegal !== 1'b1 || obs_q.size() != 0) begin
            bad++; $display("FAIL illegal_trap got halt_c=%0d illegal=%b want 2 1", obs_halt_c, illegal);
        end
`else
        total++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || obs_q.size() != 0) begin
            bad++; $display("FAIL illegal_nop got halt=%b req=%b want 0 1", halted, imem_req);
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        run_instr(5'b01100, 1'b0, -1, 0);
        total++;
        if (obs_halt_c != 4 || bus_err !== 1'b1 || obs_q.size() != 0) begin
            bad++; $display("FAIL timeout got halt_c=%0d err=%b pulses=%0d want 4 1 0", obs_halt_c, bus_err, obs_q.size());
        end
        imem_ack = 1'b1;
        repeat (5) @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (halted !== 1'b1 || bus_err !== 1'b1 || imem_req !== 1'b0 || ir_we !== 1'b0) begin
            bad++; $display("FAIL timeout_sticky got halt=%b err=%b req=%b ir=%b want 1 1 0 0", halted, bus_err, imem_req, ir_we);
        end
    endtask

    task automatic test_reset_mid_mem();
        int n = 0;
        do_reset();
        opcode = 5'b00000; imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        while (dmem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (dmem_req !== 1'b1) begin bad++; $display("FAIL mid_mem_reach got dmem_req=%b want 1", dmem_req); end
        rst_n = 1'b0;
        #1;
        total++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || rf_we !== 1'b0 || pc_we !== 1'b0) begin
            bad++; $display("FAIL mid_mem_reset got dreq=%b ireq=%b rf=%b pc=%b want 0 0 0 0", dmem_req, imem_req, rf_we, pc_we);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || dmem_req !== 1'b0 || rf_we !== 1'b0) begin
            bad++; $display("FAIL mid_mem_release got ireq=%b dreq=%b rf=%b want 1 0 0", imem_req, dmem_req, rf_we);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_load_store();
        test_branch();
        test_fence_nop();
        test_ack_on_timeout_cycle();
        test_system_halt();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
